// File: rtl/imem_loader_pkg.sv
// +----------------------------------------------------------------------------+
// | imem_loader_pkg                                                            |
// | Shared loader state encoding and frame constants.                          |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

package imem_loader_pkg;

  typedef enum logic [2:0] {
    S_LEN0 = 3'd0,
    S_LEN1 = 3'd1,
    S_DATA = 3'd2,
    S_CHK  = 3'd3,
    S_DONE = 3'd4,
    S_ERR  = 3'd5
  } state_t;

  localparam int HDR_BYTES      = 2;
  localparam int BYTES_PER_WORD = 4;
  localparam int CHK_W          = 8;

endpackage

`default_nettype wire

// File: rtl/imem_loader_word_assembler.sv
// +----------------------------------------------------------------------------+
// | word_assembler                                                             |
// | Collects little-endian bytes into 32-bit words, one-cycle word_valid.      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module word_assembler
  import imem_loader_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        clear,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        word_valid,
  output logic [31:0] word
);

  localparam logic [1:0] c_last_idx = 2'(BYTES_PER_WORD - 1);

  logic [23:0] r_shift;
  logic [1:0]  r_idx;
  logic        r_word_valid;
  logic [31:0] r_word;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_shift      <= '0;
      r_idx        <= '0;
      r_word_valid <= 1'b0;
      r_word       <= '0;
    end else begin
      r_word_valid <= 1'b0;
      if (clear) begin
        r_shift <= '0;
        r_idx   <= '0;
      end else if (byte_valid) begin
        if (r_idx == c_last_idx) begin
          r_word       <= {byte_data, r_shift};
          r_word_valid <= 1'b1;
          r_idx        <= '0;
        end else begin
          r_shift <= {byte_data, r_shift[23:8]};
          r_idx   <= r_idx + 2'd1;
        end
      end
    end
  end

  assign word_valid = r_word_valid;
  assign word       = r_word;

endmodule

`default_nettype wire

// File: rtl/imem_loader.sv
// +----------------------------------------------------------------------------+
// | imem_loader                                                                |
// | Boot loader: byte stream -> instruction RAM, holds CPU until image done.   |
// | Optional trailing XOR checksum via IMEM_LOADER_CHECKSUM_EN.                |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W = 12,
  parameter int DEPTH  = 4096
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              load_req,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              rx_ready,
  output logic              imem_wen,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_data,
  output logic              cpu_hold,
  output logic              load_done,
  output logic              load_err,
  output logic [ADDR_W:0]   words_written
);

  localparam logic [16:0]   c_depth = 17'(DEPTH);
  localparam logic [ADDR_W:0] c_one = (ADDR_W + 1)'(1);

  state_t            r_state;
  logic [7:0]        r_len_lo;
  logic [ADDR_W:0]   r_n;
  logic [ADDR_W:0]   r_k;
  logic              r_cpu_hold;
  logic              r_done;
  logic              r_err;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [CHK_W-1:0]  r_chk;
`endif

  logic              w_xfer;
  logic              w_data_byte;
  logic              w_word_valid;
  logic [31:0]       w_word;
  logic [15:0]       w_len;
  logic [ADDR_W:0]   w_k_next;

  // The write cycle after a fourth byte is the only stall inside an active state.
  assign rx_ready    = (r_state inside {S_LEN0, S_LEN1, S_DATA, S_CHK}) && !w_word_valid;
  assign w_xfer      = rx_valid && rx_ready;
  assign w_data_byte = w_xfer && (r_state == S_DATA) && !load_req;
  assign w_len       = {rx_data, r_len_lo};
  assign w_k_next    = r_k + c_one;

  word_assembler u_word_assembler (
    .clock      (clock),
    .reset      (reset),
    .clear      (load_req),
    .byte_valid (w_data_byte),
    .byte_data  (rx_data),
    .word_valid (w_word_valid),
    .word       (w_word)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state    <= S_LEN0;
      r_len_lo   <= '0;
      r_n        <= '0;
      r_k        <= '0;
      r_cpu_hold <= 1'b1;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      r_chk      <= '0;
`endif
    end else if (load_req) begin
      r_state    <= S_LEN0;
      r_len_lo   <= '0;
      r_n        <= '0;
      r_k        <= '0;
      r_cpu_hold <= 1'b1;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      r_chk      <= '0;
`endif
    end else begin
      // Release lags DONE by one cycle so the final write lands before any fetch.
      r_cpu_hold <= (r_state != S_DONE);
`ifdef IMEM_LOADER_CHECKSUM_EN
      if (w_xfer && r_state != S_CHK) r_chk <= r_chk ^ rx_data;
`endif
      case (r_state)
        S_LEN0: begin
          if (w_xfer) begin
            r_len_lo <= rx_data;
            r_state  <= S_LEN1;
          end
        end
        S_LEN1: begin
          if (w_xfer) begin
            if (w_len == 16'd0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
              r_state <= S_CHK;
`else
              r_state <= S_DONE;
              r_done  <= 1'b1;
`endif
            end else if ({1'b0, w_len} > c_depth) begin
              r_state <= S_ERR;
              r_err   <= 1'b1;
            end else begin
              r_n     <= w_len[ADDR_W:0];
              r_state <= S_DATA;
            end
          end
        end
        S_DATA: begin
          if (w_word_valid) begin
            r_k <= w_k_next;
            if (w_k_next == r_n) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
              r_state <= S_CHK;
`else
              r_state <= S_DONE;
              r_done  <= 1'b1;
`endif
            end
          end
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        S_CHK: begin
          if (w_xfer) begin
            if (rx_data == r_chk) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= S_ERR;
              r_err   <= 1'b1;
            end
          end
        end
`endif
        default: ;
      endcase
    end
  end

  assign imem_wen      = w_word_valid;
  assign imem_addr     = r_k[ADDR_W-1:0];
  assign imem_data     = w_word;
  assign cpu_hold      = r_cpu_hold;
  assign load_done     = r_done;
  assign load_err      = r_err;
  assign words_written = r_k;

endmodule

`default_nettype wire

// File: tb/tb_imem_loader.sv
// +----------------------------------------------------------------------------+
// | tb_imem_loader                                                             |
// | Directed frames; expected writes queued and checked by a write monitor.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_imem_loader;

  localparam int ADDR_W = 12;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              load_req = 1'b0;
  logic              rx_valid = 1'b0;
  logic [7:0]        rx_data = 8'h00;
  logic              rx_ready;
  logic              imem_wen;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_data;
  logic              cpu_hold;
  logic              load_done;
  logic              load_err;
  logic [ADDR_W:0]   words_written;

  int          total = 0;
  int          bad = 0;
  logic [43:0] exp_q[$];
  logic [43:0] mon_e;
  logic [7:0]  chk_acc = 8'h00;
  bit          random_gaps = 1'b0;

  imem_loader #(.ADDR_W(ADDR_W), .DEPTH(4096)) dut (
    .clock         (clock),
    .reset         (reset),
    .load_req      (load_req),
    .rx_valid      (rx_valid),
    .rx_data       (rx_data),
    .rx_ready      (rx_ready),
    .imem_wen      (imem_wen),
    .imem_addr     (imem_addr),
    .imem_data     (imem_data),
    .cpu_hold      (cpu_hold),
    .load_done     (load_done),
    .load_err      (load_err),
    .words_written (words_written)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic expect_write(input logic [11:0] addr, input logic [31:0] data);
    exp_q.push_back({addr, data});
  endtask

  // Called just after a rising edge; returns just after the edge that took the byte.
  task automatic send_byte(input logic [7:0] b);
    int guard;
    guard = 0;
    if (random_gaps) begin
      rx_valid = 1'b0;
      repeat ($urandom_range(0, 2)) begin
        @(posedge clock);
        #1;
      end
    end
    chk_acc  = chk_acc ^ b;
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge clock);
    while (!rx_ready && guard < 50) begin
      @(negedge clock);
      guard++;
    end
    if (!rx_ready) begin
      total++;
      bad++;
      $display("FAIL byte_timeout: rx_ready stuck at 0 for byte %0h, required 1", b);
    end
    @(posedge clock);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic pulse_load_req();
    load_req = 1'b1;
    @(posedge clock);
    #1;
    load_req = 1'b0;
    chk_acc  = 8'h00;
  endtask

  always @(negedge clock) begin
    if (!reset && imem_wen) begin
      check("ready_in_write", rx_ready, 0);
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_write: got addr %0h data %0h, required no write", imem_addr, imem_data);
      end else begin
        mon_e = exp_q.pop_front();
        check("wr_addr", imem_addr, mon_e[43:32]);
        check("wr_data", imem_data, mon_e[31:0]);
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation still running, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clock);
    #1;
    check("rst_ready", rx_ready, 1);
    check("rst_wen", imem_wen, 0);
    check("rst_addr", imem_addr, 0);
    check("rst_data", imem_data, 0);
    check("rst_hold", cpu_hold, 1);
    check("rst_done", load_done, 0);
    check("rst_err", load_err, 0);
    check("rst_words", words_written, 0);
    reset = 1'b0;
    @(posedge clock);
    #1;

    // Two-word image, back to back.
    expect_write(12'd0, 32'h44332211);
    expect_write(12'd1, 32'hDDCCBBAA);
    send_byte(8'h02); send_byte(8'h00);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
    send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC); send_byte(8'hDD);
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_byte(chk_acc);
    check("t1_done", load_done, 1);
`else
    check("t1_hold_in_write", cpu_hold, 1);
    @(posedge clock);
    #1;
    check("t1_done", load_done, 1);
    check("t1_hold_still_high", cpu_hold, 1);
`endif
    check("t1_words", words_written, 2);
    @(posedge clock);
    #1;
    check("t1_hold_fall", cpu_hold, 0);

    // Empty image.
    pulse_load_req();
    check("t2_hold_after_req", cpu_hold, 1);
    check("t2_done_cleared", load_done, 0);
    check("t2_words_cleared", words_written, 0);
    send_byte(8'h00); send_byte(8'h00);
`ifdef IMEM_LOADER_CHECKSUM_EN
    check("t2_wait_chk", load_done, 0);
    send_byte(chk_acc);
`endif
    check("t2_done", load_done, 1);
    check("t2_ready_low", rx_ready, 0);
    @(posedge clock);
    #1;
    check("t2_hold_fall", cpu_hold, 0);

    // Oversized count 4097.
    pulse_load_req();
    send_byte(8'h01); send_byte(8'h10);
    check("t3_err", load_err, 1);
    check("t3_ready_low", rx_ready, 0);
    repeat (3) @(posedge clock);
    #1;
    check("t3_hold", cpu_hold, 1);
    check("t3_not_done", load_done, 0);
    check("t3_words", words_written, 0);

    // Three words with random idle gaps.
    pulse_load_req();
    check("t4_err_cleared", load_err, 0);
    expect_write(12'd0, 32'h04030201);
    expect_write(12'd1, 32'h08070605);
    expect_write(12'd2, 32'h0C0B0A09);
    random_gaps = 1'b1;
    send_byte(8'h03); send_byte(8'h00);
    for (int i = 1; i <= 12; i++) send_byte(8'(i));
    random_gaps = 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_byte(chk_acc);
`endif
    repeat (2) @(posedge clock);
    #1;
    check("t4_done", load_done, 1);
    check("t4_words", words_written, 3);
    check("t4_hold", cpu_hold, 0);

    // Abort mid-word, then a fresh one-word frame.
    pulse_load_req();
    expect_write(12'd0, 32'hDEADBEEF);
    send_byte(8'h02); send_byte(8'h00);
    send_byte(8'hEF); send_byte(8'hBE); send_byte(8'hAD); send_byte(8'hDE);
    send_byte(8'h01); send_byte(8'h02);
    pulse_load_req();
    check("t5_words_cleared", words_written, 0);
    check("t5_hold", cpu_hold, 1);
    expect_write(12'd0, 32'h3CC3A55A);
    send_byte(8'h01); send_byte(8'h00);
    send_byte(8'h5A); send_byte(8'hA5); send_byte(8'hC3); send_byte(8'h3C);
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_byte(chk_acc);
`endif
    repeat (2) @(posedge clock);
    #1;
    check("t5_done", load_done, 1);
    check("t5_words", words_written, 1);

`ifdef IMEM_LOADER_CHECKSUM_EN
    // Corrupted checksum.
    pulse_load_req();
    expect_write(12'd0, 32'h78563412);
    send_byte(8'h01); send_byte(8'h00);
    send_byte(8'h12); send_byte(8'h34); send_byte(8'h56); send_byte(8'h78);
    send_byte(chk_acc ^ 8'hFF);
    repeat (2) @(posedge clock);
    #1;
    check("t6_err", load_err, 1);
    check("t6_hold", cpu_hold, 1);
    check("t6_not_done", load_done, 0);
`endif

    repeat (3) @(posedge clock);
    #1;
    check("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/imem_loader.md
# imem_loader

Synthesizable boot loader that fills the processor's instruction memory from a byte stream (host link, UART receiver, or bench driver) and holds the processor in reset until the image is complete. It sits between the byte source and the 12-bit-address, 32-bit-word instruction RAM, replacing the fixed `.mem` preload so new programs can be run without re-synthesis. It is the writer on the instruction-memory interface that the processor and harness only ever read.

## Interface
- `ADDR_W`, 12: instruction-memory word-address width.
- `DEPTH`, 4096: maximum words accepted; must be at most 2**ADDR_W.

- `clock`  in  1: single clock; all state updates on the rising edge.
- `reset`  in  1: asynchronous, active-high.
- `load_req`  in  1: one-cycle pulse; aborts any activity and restarts at header.
- `rx_valid`  in  1: byte source has a byte.
- `rx_data`  in  8: byte value.
- `rx_ready`  out  1: loader accepts a byte this cycle.
- `imem_wen`  out  1: instruction-memory write enable, one-cycle pulse per word.
- `imem_addr`  out  ADDR_W: word address of the write.
- `imem_data`  out  32: word to write.
- `cpu_hold`  out  1: drives processor `reset`; high while loading.
- `load_done`  out  1: image fully written (and verified, if enabled).
- `load_err`  out  1: header or checksum error; sticky until `reset`/`load_req`.
- `words_written`  out  ADDR_W+1: words committed in the current load.

## Operation
- Frame: 2-byte word count N (little-endian, 16 bits), then N words of 4 bytes each, little-endian (first byte = bits 7:0), then a checksum byte only if `IMEM_LOADER_CHECKSUM_EN`.
- States: `LEN0`, `LEN1`, `DATA`, `CHK` (macro only), `DONE`, `ERR`.
- A byte transfers on a rising edge with `rx_valid && rx_ready`. `rx_ready` = 1 in `LEN0`, `LEN1`, `DATA`, `CHK`; 0 in `DONE`, `ERR`, and during the write cycle after a word's fourth byte.
- `LEN0` -> `LEN1` on a byte (low count). `LEN1` -> on a byte: N = 0 -> `CHK`/`DONE`; N > DEPTH -> `ERR`; otherwise `DATA`.
- `DATA`: bytes shift into the word assembler. On the fourth byte, the next cycle has `imem_wen` = 1, `imem_addr` = word index k (starting at 0), and `imem_data` = the assembled word. Then k and `words_written` increment.
- After the write of word N-1: go to `CHK` if the macro is defined, else `DONE`.
- `DONE`: `cpu_hold` = 0, `load_done` = 1. `ERR`: `cpu_hold` = 1, `load_err` = 1.
- `load_req` in any state: go to `LEN0`, raise `cpu_hold`, clear counters, flags, and any partial word. It has priority over a byte transfer in the same cycle. Words already written are not erased.
- `rx_valid` with no transfer: no effect. Bytes are never dropped while `rx_ready` = 1.

## Timing
- Reset values: state `LEN0`, `rx_ready` 1, `imem_wen` 0, `imem_addr` 0, `imem_data` 0, `cpu_hold` 1, `load_done` 0, `load_err` 0, `words_written` 0.
- Reset mid-load has the same effect: the partial word is discarded and memory is left untouched.
- Throughput: 4 data bytes plus 1 write cycle per word, i.e. 5 cycles per word at full rate.
- The fourth byte of the final word accepted at edge E:
  - write cycle is E..E+1;
  - state reaches `DONE` at E+1;
  - `cpu_hold` falls at E+2, guaranteeing the last write is committed before the first fetch.
- All outputs are registered; no combinational path from `rx_*` to outputs except through `rx_ready`'s state decode.

## Configuration
- `IMEM_LOADER_CHECKSUM_EN` defined:
  - a trailing byte follows the data;
  - the expected value is the XOR of all header and data bytes;
  - a match goes to `DONE`, a mismatch goes to `ERR` with `cpu_hold` kept high;
  - N = 0 still requires the checksum byte.
- Undefined: no `CHK` state and no checksum register; `DONE` follows the final write directly.

## Structure
- Package `imem_loader_pkg`: state enum, `HDR_BYTES` = 2, `BYTES_PER_WORD` = 4, checksum width 8.
- Sub-module `word_assembler`:
  - byte shift register plus 2-bit byte index;
  - emits `word_valid` and the 32-bit word;
  - cleared by `load_req` and `reset`.

## Test plan
- Header 0x02,0x00 then bytes 11 22 33 44 AA BB CC DD -> writes 0x44332211 @0 and 0xDDCCBBAA @1; `cpu_hold` falls 2 cycles after the second write; `words_written` = 2.
- Header with N = 0 (no macro) -> `DONE` after the second header byte, no `imem_wen` pulses.
- Header with N = 4097 -> `ERR`, `rx_ready` 0, `cpu_hold` 1, no writes.
- `rx_valid` toggled randomly across a 3-word image -> same writes as a back-to-back stream, with `rx_ready` low in each write cycle.
- `load_req` after 2 bytes of word 1, then a fresh 1-word frame -> a single write at address 0 with the new data.
- With the macro: correct XOR -> `load_done` = 1; corrupted checksum -> `load_err` = 1 and `cpu_hold` = 1.
